// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and writeback stage: result select, sub-word load extract, misalign flag, minstret counter.
// Latency: one cycle from M inputs to W outputs; all outputs are combinational from W state only.
// Backpressure: StallW_i holds W, FlushW_i loads a bubble (flush wins over stall, reset wins over both).
//
// Ports:
//   clk_i, rst_i        core clock, synchronous active-high reset
//   *M_i                memory-stage instruction fields captured into W
//   StallW_i, FlushW_i  hold W / load a bubble into W
//   ResultW_o, RdW_o, RegWriteW_o  register-file write port
//   ValidW_o, MisalignW_o          W status
//   InstRetW_o          64-bit retired-instruction count
module writeback_stage #(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ValidM_i,
  input  logic             RegWriteM_i,
  input  logic [RADDR-1:0] RdM_i,
  input  logic [1:0]       ResultSrcM_i,
  input  logic [2:0]       LoadTypeM_i,
  input  logic [XLEN-1:0]  ALUResultM_i,
  input  logic [XLEN-1:0]  ReadDataM_i,
  input  logic [XLEN-1:0]  PCPlus4M_i,
  input  logic [XLEN-1:0]  ImmExtM_i,
  input  logic             StallW_i,
  input  logic             FlushW_i,
  output logic [XLEN-1:0]  ResultW_o,
  output logic [RADDR-1:0] RdW_o,
  output logic             RegWriteW_o,
  output logic             ValidW_o,
  output logic             MisalignW_o,
  output logic [63:0]      InstRetW_o
);

  localparam int OFFW = $clog2(XLEN / 8);

  logic             r_valid;
  logic             r_regwrite;
  logic [RADDR-1:0] r_rd;
  logic [1:0]       r_src;
  logic [2:0]       r_lt;
  logic [XLEN-1:0]  r_alu;
  logic [XLEN-1:0]  r_rdata;
  logic [XLEN-1:0]  r_pc4;
  logic [XLEN-1:0]  r_imm;
  logic [63:0]      r_instret;

  logic [OFFW-1:0]  w_off;
  logic [XLEN-1:0]  w_sh;
  logic [7:0]       w_b;
  logic [15:0]      w_h;
  logic [31:0]      w_w;
  logic [XLEN-1:0]  w_lw;
  logic [XLEN-1:0]  w_lwu;
  logic [XLEN-1:0]  w_ld;
  logic [XLEN-1:0]  w_load;
  logic             w_misalign;
  logic             w_retire;
  logic [63:0]      w_instret_nxt;

  // W register. On flush only the qualifiers are cleared; the payload is
  // don't-care once valid is low, so it is simply left alone.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_rd       <= '0;
      r_src      <= 2'b00;
      r_lt       <= 3'b000;
      r_alu      <= '0;
      r_rdata    <= '0;
      r_pc4      <= '0;
      r_imm      <= '0;
    end else if (FlushW_i) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
    end else if (!StallW_i) begin
      r_valid    <= ValidM_i;
      r_regwrite <= RegWriteM_i;
      r_rd       <= RdM_i;
      r_src      <= ResultSrcM_i;
      r_lt       <= LoadTypeM_i;
      r_alu      <= ALUResultM_i;
      r_rdata    <= ReadDataM_i;
      r_pc4      <= PCPlus4M_i;
      r_imm      <= ImmExtM_i;
    end
  end

  // Move the addressed byte lane down to bit 0; every load width then
  // just takes the low bits of the shifted word.
  assign w_off = r_alu[OFFW-1:0];
  assign w_sh  = r_rdata >> {w_off, 3'b000};
  assign w_b   = w_sh[7:0];
  assign w_h   = w_sh[15:0];
  assign w_w   = w_sh[31:0];

  // Word and doubleword forms only differ from a plain pass-through on RV64.
  generate
    if (XLEN == 64) begin : g_rv64
      assign w_lw  = {{32{w_w[31]}}, w_w};
      assign w_lwu = {32'b0, w_w};
      assign w_ld  = w_sh;
    end else begin : g_rv32
      assign w_lw  = w_w;
      assign w_lwu = '0;
      assign w_ld  = '0;
    end
  endgenerate

  always_comb begin
    w_load = '0;
    case (r_lt)
      3'b000:  w_load = {{(XLEN-8){w_b[7]}}, w_b};
      3'b100:  w_load = {{(XLEN-8){1'b0}}, w_b};
      3'b001:  w_load = {{(XLEN-16){w_h[15]}}, w_h};
      3'b101:  w_load = {{(XLEN-16){1'b0}}, w_h};
      3'b010:  w_load = w_lw;
      3'b110:  w_load = w_lwu;
      3'b011:  w_load = w_ld;
      default: w_load = '0;
    endcase
  end

  // Access width is encoded in funct3[1:0]; the doubleword check only
  // looks at address bit 2 when the datapath actually has 8 byte lanes.
  always_comb begin
    w_misalign = 1'b0;
    if (r_valid && (r_src == 2'b01)) begin
      case (r_lt[1:0])
        2'b01:   w_misalign = r_alu[0];
        2'b10:   w_misalign = |r_alu[1:0];
        2'b11:   w_misalign = (|r_alu[1:0]) || ((XLEN == 64) && r_alu[2]);
        default: w_misalign = 1'b0;
      endcase
    end
  end

  always_comb begin
    ResultW_o = r_alu;
    case (r_src)
      2'b00:   ResultW_o = r_alu;
      2'b01:   ResultW_o = w_load;
      2'b10:   ResultW_o = r_pc4;
      default: ResultW_o = r_imm;
    endcase
  end

  assign RdW_o       = r_rd;
  assign ValidW_o    = r_valid;
  assign MisalignW_o = w_misalign;
  assign RegWriteW_o = r_valid && r_regwrite && !w_misalign && (r_rd != '0);

  // An instruction retires on the edge it leaves W: either W advances
  // normally or a flush pushes it out. A stalled entry is not counted yet.
  assign w_retire      = r_valid && !w_misalign && (!StallW_i || FlushW_i);
  assign w_instret_nxt = r_instret + {63'b0, w_retire};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_instret <= 64'd0;
    end else begin
      r_instret <= w_instret_nxt;
    end
  end

  assign InstRetW_o = r_instret;

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

  typedef struct {
    string       tag;
    logic [63:0] res;
    logic [63:0] rd;
    logic        rw;
    logic        v;
    logic        mis;
    bit          chk;
    logic [63:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld_m, rw_m;
  logic [4:0]  rd_m;
  logic [1:0]  src_m;
  logic [2:0]  lt_m;
  logic [63:0] alu_m, rdata_m, pc4_m, imm_m;
  logic        stall, flush;

  logic [31:0] res32;
  logic [4:0]  rd32;
  logic        rw32, v32, mis32;
  logic [63:0] cnt32;
  logic [63:0] res64;
  logic [4:0]  rd64;
  logic        rw64, v64, mis64;
  logic [63:0] cnt64;

  int   tests = 0;
  int   fails = 0;
  bit   sel64 = 1'b0;
  bit   m_preset = 1'b0;
  logic m_valid = 1'b0;
  logic m_mis = 1'b0;
  logic [63:0] m_cnt = 64'd0;
  exp_t sb[$];

  always #5 clk = ~clk;

  writeback_stage #(.XLEN(32), .RADDR(5)) dut32 (
    .clk_i(clk), .rst_i(rst), .ValidM_i(vld_m), .RegWriteM_i(rw_m), .RdM_i(rd_m),
    .ResultSrcM_i(src_m), .LoadTypeM_i(lt_m), .ALUResultM_i(alu_m[31:0]),
    .ReadDataM_i(rdata_m[31:0]), .PCPlus4M_i(pc4_m[31:0]), .ImmExtM_i(imm_m[31:0]),
    .StallW_i(stall), .FlushW_i(flush), .ResultW_o(res32), .RdW_o(rd32),
    .RegWriteW_o(rw32), .ValidW_o(v32), .MisalignW_o(mis32), .InstRetW_o(cnt32)
  );

  writeback_stage #(.XLEN(64), .RADDR(5)) dut64 (
    .clk_i(clk), .rst_i(rst), .ValidM_i(vld_m), .RegWriteM_i(rw_m), .RdM_i(rd_m),
    .ResultSrcM_i(src_m), .LoadTypeM_i(lt_m), .ALUResultM_i(alu_m),
    .ReadDataM_i(rdata_m), .PCPlus4M_i(pc4_m), .ImmExtM_i(imm_m),
    .StallW_i(stall), .FlushW_i(flush), .ResultW_o(res64), .RdW_o(rd64),
    .RegWriteW_o(rw64), .ValidW_o(v64), .MisalignW_o(mis64), .InstRetW_o(cnt64)
  );

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%h expected 0x%h", name, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic [4:0] rd, input logic [1:0] src,
                       input logic [2:0] lt, input logic [63:0] alu, input logic [63:0] rdata,
                       input logic [63:0] pc4, input logic [63:0] imm);
    vld_m = v; rw_m = rw; rd_m = rd; src_m = src; lt_m = lt;
    alu_m = alu; rdata_m = rdata; pc4_m = pc4; imm_m = imm;
  endtask

  // One clock edge: push the expected W state, clock, then pop and compare.
  // The retire count comes from a model of which entry leaves W on the edge.
  task automatic step(input string tag, input logic r, input logic st, input logic fl,
                      input logic [63:0] eres, input logic [4:0] erd, input logic erw,
                      input logic ev, input logic emis, input bit chk);
    exp_t e;
    rst = r; stall = st; flush = fl;
    if (r) m_cnt = 64'd0;
    else if (m_preset) m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    else if (m_valid && !m_mis && (!st || fl)) m_cnt = m_cnt + 64'd1;
    m_valid = ev;
    m_mis   = emis;
    e.tag = tag; e.res = eres; e.rd = {59'b0, erd}; e.rw = erw; e.v = ev;
    e.mis = emis; e.chk = chk; e.cnt = m_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (e.chk) begin
      check({e.tag, ".result"}, sel64 ? res64 : {32'b0, res32}, e.res);
      check({e.tag, ".rd"}, sel64 ? {59'b0, rd64} : {59'b0, rd32}, e.rd);
    end
    check({e.tag, ".regwrite"}, {63'b0, sel64 ? rw64 : rw32}, {63'b0, e.rw});
    check({e.tag, ".valid"}, {63'b0, sel64 ? v64 : v32}, {63'b0, e.v});
    check({e.tag, ".misalign"}, {63'b0, sel64 ? mis64 : mis32}, {63'b0, e.mis});
    check({e.tag, ".instret"}, sel64 ? cnt64 : cnt32, e.cnt);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(0, 0, 0, 2'b00, 3'b000, 64'h0, 64'h0, 64'h0, 64'h0);

    // ---- RV32 instance ----
    step("reset", 1, 0, 0, 64'h0, 0, 0, 0, 0, 1);
    drive(1, 1, 5, 2'b00, 3'b000, 64'h1234, 64'h0, 64'h0, 64'h0);
    step("alu", 0, 0, 0, 64'h1234, 5, 1, 1, 0, 1);
    drive(1, 1, 6, 2'b01, 3'b000, 64'h103, 64'h80FF_0000, 64'h0, 64'h0);
    step("lb", 0, 0, 0, 64'hFFFF_FF80, 6, 1, 1, 0, 1);
    drive(1, 1, 6, 2'b01, 3'b100, 64'h103, 64'h80FF_0000, 64'h0, 64'h0);
    step("lbu", 0, 0, 0, 64'h0000_0080, 6, 1, 1, 0, 1);
    drive(1, 1, 6, 2'b01, 3'b001, 64'h102, 64'h80FF_0000, 64'h0, 64'h0);
    step("lh", 0, 0, 0, 64'hFFFF_80FF, 6, 1, 1, 0, 1);
    drive(1, 1, 6, 2'b01, 3'b101, 64'h102, 64'h80FF_0000, 64'h0, 64'h0);
    step("lhu", 0, 0, 0, 64'h0000_80FF, 6, 1, 1, 0, 1);
    drive(1, 1, 7, 2'b01, 3'b010, 64'h102, 64'h80FF_0000, 64'h0, 64'h0);
    step("lw_mis", 0, 0, 0, 64'h0, 7, 0, 1, 1, 0);
    drive(1, 1, 8, 2'b01, 3'b010, 64'h100, 64'h80FF_0000, 64'h0, 64'h0);
    step("lw", 0, 0, 0, 64'h80FF_0000, 8, 1, 1, 0, 1);
    drive(1, 1, 0, 2'b00, 3'b000, 64'h55, 64'h0, 64'h0, 64'h0);
    step("x0", 0, 0, 0, 64'h55, 0, 0, 1, 0, 1);
    drive(1, 1, 1, 2'b10, 3'b000, 64'h0, 64'h0, 64'h48, 64'h0);
    step("jal", 0, 0, 0, 64'h48, 1, 1, 1, 0, 1);
    drive(1, 1, 2, 2'b11, 3'b000, 64'h0, 64'h0, 64'h0, 64'h1234_5000);
    step("lui", 0, 0, 0, 64'h1234_5000, 2, 1, 1, 0, 1);
    drive(1, 1, 9, 2'b00, 3'b000, 64'h999, 64'h0, 64'h0, 64'h0);
    for (int i = 0; i < 3; i++) begin
      step($sformatf("stall%0d", i), 0, 1, 0, 64'h1234_5000, 2, 1, 1, 0, 1);
    end
    step("release", 0, 0, 0, 64'h999, 9, 1, 1, 0, 1);
    drive(1, 1, 10, 2'b00, 3'b000, 64'hABC, 64'h0, 64'h0, 64'h0);
    step("flush_stall", 0, 1, 1, 64'h0, 0, 0, 0, 0, 0);
    step("flush_bubble", 0, 0, 1, 64'h0, 0, 0, 0, 0, 0);
    drive(1, 1, 3, 2'b00, 3'b000, 64'h77, 64'h0, 64'h0, 64'h0);
    step("alu2", 0, 0, 0, 64'h77, 3, 1, 1, 0, 1);
    step("stall_pre_rst", 0, 1, 0, 64'h77, 3, 1, 1, 0, 1);
    step("rst_in_stall", 1, 1, 0, 64'h0, 0, 0, 0, 0, 1);

    // Preset the counter to all ones through its next-state net.
    drive(1, 1, 4, 2'b00, 3'b000, 64'hAA, 64'h0, 64'h0, 64'h0);
    force dut32.w_instret_nxt = 64'hFFFF_FFFF_FFFF_FFFF;
    m_preset = 1'b1;
    step("preset", 0, 0, 0, 64'hAA, 4, 1, 1, 0, 1);
    m_preset = 1'b0;
    release dut32.w_instret_nxt;
    drive(0, 0, 0, 2'b00, 3'b000, 64'h0, 64'h0, 64'h0, 64'h0);
    step("wrap", 0, 0, 0, 64'h0, 0, 0, 0, 0, 1);

    // ---- RV64 instance ----
    sel64 = 1'b1;
    step("rst64", 1, 0, 0, 64'h0, 0, 0, 0, 0, 1);
    drive(1, 1, 11, 2'b01, 3'b110, 64'h1004, 64'h8000_0001_DEAD_BEEF, 64'h0, 64'h0);
    step("lwu64", 0, 0, 0, 64'h0000_0000_8000_0001, 11, 1, 1, 0, 1);
    drive(1, 1, 12, 2'b01, 3'b011, 64'h1004, 64'h8000_0001_DEAD_BEEF, 64'h0, 64'h0);
    step("ld_mis64", 0, 0, 0, 64'h0, 12, 0, 1, 1, 0);
    drive(1, 1, 12, 2'b01, 3'b011, 64'h1000, 64'h8000_0001_DEAD_BEEF, 64'h0, 64'h0);
    step("ld64", 0, 0, 0, 64'h8000_0001_DEAD_BEEF, 12, 1, 1, 0, 1);
    drive(1, 1, 13, 2'b01, 3'b010, 64'h1004, 64'h8000_0001_DEAD_BEEF, 64'h0, 64'h0);
    step("lw64", 0, 0, 0, 64'hFFFF_FFFF_8000_0001, 13, 1, 1, 0, 1);
    drive(0, 0, 0, 2'b00, 3'b000, 64'h0, 64'h0, 64'h0, 64'h0);
    step("bubble64", 0, 0, 0, 64'h0, 0, 0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Parametrised MEM/WB pipeline register and writeback stage for the pipelined RV32I core, generalisable to RV64I. It captures memory-stage results on each clock and selects the register-file write value. It also extracts and sign- or zero-extends sub-word load data and flags misaligned loads. Stall and flush are handled inside the block, and a 64-bit retired-instruction counter feeds `minstret`.

## Interface
Parameters:
- `XLEN`, 32: datapath width; 32 or 64 only.
- `RADDR`, 5: register-address width.

Ports (one clock; reset is synchronous and active-high):
- `clk_i`  in  1  core clock; all state updates on the rising edge.
- `rst_i`  in  1  synchronous active-high reset.
- `ValidM_i`  in  1  M-stage entry is a real instruction.
- `RegWriteM_i`  in  1  instruction writes `rd`.
- `RdM_i`  in  RADDR  destination register.
- `ResultSrcM_i`  in  2  00 ALU, 01 load, 10 PC+4, 11 immediate (LUI).
- `LoadTypeM_i`  in  3  funct3 of the load.
- `ALUResultM_i`  in  XLEN  ALU result; also the load address.
- `ReadDataM_i`  in  XLEN  raw aligned memory word.
- `PCPlus4M_i`  in  XLEN  PC+4.
- `ImmExtM_i`  in  XLEN  extended immediate.
- `StallW_i`  in  1  hold the W register.
- `FlushW_i`  in  1  load a bubble into W.
- `ResultW_o`  out  XLEN  writeback value.
- `RdW_o`  out  RADDR  writeback register.
- `RegWriteW_o`  out  1  register-file write enable.
- `ValidW_o`  out  1  W holds a real instruction.
- `MisalignW_o`  out  1  W holds a misaligned load.
- `InstRetW_o`  out  64  retired-instruction count.

## Operation
- The W register holds: valid, regwrite, rd, resultsrc, loadtype, ALU result, read data, PC+4 and immediate.
- Register update, one rule per edge, highest priority first:
  - `rst_i`: all fields 0.
  - `FlushW_i`: valid and regwrite are 0; other fields are don't-care.
  - `StallW_i`: hold.
  - Otherwise: capture all M inputs.
- Flush has priority over stall when both are high.
- `ResultW_o` is combinational from the W register:
  - 00: ALU result.
  - 01: extracted load value.
  - 10: PC+4.
  - 11: immediate.
- Load extraction uses the byte offset `off = ALU[log2(XLEN/8)-1:0]`. Codes:
  - 000 LB: byte at `off`, sign-extended.
  - 100 LBU: byte at `off`, zero-extended.
  - 001 LH: halfword at `off`, sign-extended.
  - 101 LHU: halfword at `off`, zero-extended.
  - 010 LW: word at `off`, sign-extended to XLEN (no-op when XLEN=32).
  - 110 LWU (XLEN=64 only): word at `off`, zero-extended.
  - 011 LD (XLEN=64 only): full doubleword.
  - Any other code: result 0.
- Misalignment:
  - `MisalignW_o` = valid && resultsrc==01 && the access width does not divide `off` (halfword: `off[0]`; word: `off[1:0]`; doubleword: `off[2:0]`).
  - It is 0 for byte loads and for non-load sources.
- `RegWriteW_o` = valid && regwrite && !MisalignW_o && rd != 0. The x0 write is suppressed here.
- `RdW_o` is always the registered rd.
- `InstRetW_o` increments by 1 on an edge where all of the following hold:
  - `ValidW_o` is 1 and `MisalignW_o` is 0;
  - `StallW_i` is 0, or `FlushW_i` is 1.
- A stalled instruction is counted only once, when it leaves W. The counter wraps from 2^64-1 to 0.

## Timing
- Latency: M inputs appear on W outputs 1 cycle after a non-stalled, non-flushed edge.
- All outputs are combinational from W state; there is no M-to-W combinational path.
- Reset values (and the values held while `rst_i` is high):
  - `ValidW_o`, `RegWriteW_o`, `MisalignW_o`: 0.
  - `RdW_o`: 0; `ResultW_o`: 0 (ALU source, ALU field 0).
  - `InstRetW_o`: 0.
- Reset asserted mid-stall clears W and the counter on the same edge; it has priority over flush and stall.
- A flushed W entry drives `RegWriteW_o` 0 on the following cycle. The instruction leaving W on the flush edge is still counted.
- A stall held N cycles keeps every output constant for N cycles.

## Test plan
- Reset → all outputs 0. Release, then ALU op with rd=5, ALU=0x1234, src=00 → next cycle `ResultW_o`=0x1234, `RegWriteW_o`=1, `RdW_o`=5.
- LB at address 0x103 with `ReadDataM_i`=0x80FF_0000:
  - LB → `ResultW_o`=0xFFFF_FF80.
  - Same access as LBU → 0x0000_0080.
  - LH at 0x102 → 0xFFFF_80FF.
- LW at 0x102 → `MisalignW_o`=1, `RegWriteW_o`=0, `InstRetW_o` not incremented on exit.
- rd=0 with regwrite=1 → `RegWriteW_o`=0. JAL with src=10, PC+4=0x48 → `ResultW_o`=0x48.
- Stall held 3 cycles on a valid entry → outputs frozen; counter +1 only on the release edge.
  - `FlushW_i` and `StallW_i` both high → bubble loaded (`ValidW_o`=0), counter +1.
  - Counter preset to 0xFFFF_FFFF_FFFF_FFFF by forcing the state → wraps to 0.
- XLEN=64 build:
  - LWU at off=4 with data 0x8000_0001_xxxx_xxxx → 0x0000_0000_8000_0001.
  - LD at off=4 → misaligned.
